// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: memory-side target for the LC-3b mem_read/mem_write/mem_resp handshake.
// Backs a DEPTH_WORDS x 16-bit array with byte-lane write masking. Each accepted request
// completes with a one-cycle mem_resp pulse LATENCY cycles after acceptance.
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   mem_read_i     read request, held until mem_resp_o is sampled
//   mem_write_i    write request, held until mem_resp_o is sampled (wins over read)
//   mem_wmask_i    byte-lane enables, bit0 = [7:0], bit1 = [15:8]
//   mem_address_i  byte address, bit0 ignored, upper bits alias modulo DEPTH_WORDS
//   mem_wdata_i    write data
//   mem_resp_o     one-cycle completion pulse
//   mem_rdata_o    registered read data, valid while mem_resp_o is high

package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;
endpackage

module lc3b_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_read_i,
    input  logic                      mem_write_i,
    input  lc3b_types::lc3b_mem_wmask mem_wmask_i,
    input  lc3b_types::lc3b_word      mem_address_i,
    input  lc3b_types::lc3b_word      mem_wdata_i,
    output logic                      mem_resp_o,
    output lc3b_types::lc3b_word      mem_rdata_o
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [AW-1:0]             addr_q, addr_d;
    lc3b_types::lc3b_word      wdata_q, wdata_d;
    lc3b_types::lc3b_mem_wmask wmask_q, wmask_d;
    logic                      we_q, we_d;
    lc3b_types::lc3b_word      rdata_q, rdata_d;

    lc3b_types::lc3b_word      mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx_in;
    assign idx_in = mem_address_i[AW:1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (mem_read_i || mem_write_i) begin
                    addr_d  = idx_in;
                    wdata_d = mem_wdata_i;
                    wmask_d = mem_wmask_i;
                    we_d    = mem_write_i;
                    cnt_d   = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = StResp;
                        // Address is being captured this same edge, so read via the live index.
                        rdata_d = mem_q[idx_in];
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (!mem_read_i && !mem_write_i) begin
                    // Initiator withdrew the request: drop it silently.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = StResp;
                        // Pre-write word, so a read+write returns the old contents.
                        rdata_d = mem_q[addr_q];
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset. The write commits on the edge leaving StResp; a reset in
    // StResp forces StIdle first, so the pending write is discarded.
    always_ff @(posedge clk) begin
        if (state_q == StResp && we_q) begin
            if (wmask_q[0]) mem_q[addr_q][7:0]  <= wdata_q[7:0];
            if (wmask_q[1]) mem_q[addr_q][15:8] <= wdata_q[15:8];
        end
    end

    assign mem_resp_o  = (state_q == StResp);
    assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Testbench for lc3b_mem_responder: two instances (LATENCY=3 and LATENCY=1), directed
// stimulus, expected responses queued at issue time and checked by per-instance monitors.
module tb_lc3b_mem_responder;
    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic        clk;
    logic        rst_n;
    logic        rd   [2];
    logic        wr   [2];
    logic [1:0]  wm   [2];
    logic [15:0] ad   [2];
    logic [15:0] wd   [2];
    logic        resp [2];
    logic [15:0] rdat [2];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        bit          chk;
        logic [15:0] rdata;
        string       nm;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT0)) u_dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read_i    (rd[0]),
        .mem_write_i   (wr[0]),
        .mem_wmask_i   (wm[0]),
        .mem_address_i (ad[0]),
        .mem_wdata_i   (wd[0]),
        .mem_resp_o    (resp[0]),
        .mem_rdata_o   (rdat[0])
    );

    lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT1)) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read_i    (rd[1]),
        .mem_write_i   (wr[1]),
        .mem_wmask_i   (wm[1]),
        .mem_address_i (ad[1]),
        .mem_wdata_i   (wd[1]),
        .mem_resp_o    (resp[1]),
        .mem_rdata_o   (rdat[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check_pop(input int d);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (d == 0) begin
            if (sb0.size() != 0) begin e = sb0.pop_front(); have = 1'b1; end
        end else begin
            if (sb1.size() != 0) begin e = sb1.pop_front(); have = 1'b1; end
        end
        if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp dut%0d: got resp at cycle %0d required none", d, cyc);
        end else begin
            chk({e.nm, "_latency"}, 32'(cyc), 32'(e.cyc));
            if (e.chk) chk({e.nm, "_rdata"}, {16'h0, rdat[d]}, {16'h0, e.rdata});
        end
    endtask

    always @(negedge clk) if (resp[0] === 1'b1) check_pop(0);
    always @(negedge clk) if (resp[1] === 1'b1) check_pop(1);

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic issue(input int d, input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] wdat, input logic [1:0] m, input bit c,
                         input logic [15:0] exp, input string nm);
        exp_t e;
        bit   got;
        rd[d] = r;
        wr[d] = w;
        ad[d] = a;
        wd[d] = wdat;
        wm[d] = m;
        e.cyc   = cyc + lat(d);
        e.chk   = c;
        e.rdata = exp;
        e.nm    = nm;
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            // Captured on acceptance; scrambling afterwards must not matter.
            ad[d] = ~a;
            wd[d] = ~wdat;
            wm[d] = ~m;
            if (resp[d] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no resp required resp within 40 cycles", nm);
            if (d == 0) void'(sb0.pop_back()); else void'(sb1.pop_back());
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_word(input int d, input logic [15:0] a, input logic [15:0] v,
                           input logic [1:0] m, input string nm);
        issue(d, 1'b0, 1'b1, a, v, m, 1'b0, 16'h0, nm);
    endtask

    task automatic rd_word(input int d, input logic [15:0] a, input logic [15:0] exp,
                           input string nm);
        issue(d, 1'b1, 1'b0, a, 16'h0, 2'b00, 1'b1, exp, nm);
    endtask

    initial begin
        int resp_seen;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; wm[d] = 2'b00; ad[d] = 16'h0; wd[d] = 16'h0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_resp0",  {31'h0, resp[0]}, 32'h0);
        chk("reset_rdata0", {16'h0, rdat[0]}, 32'h0);
        chk("reset_resp1",  {31'h0, resp[1]}, 32'h0);
        chk("reset_rdata1", {16'h0, rdat[1]}, 32'h0);

        // Full word write then read.
        wr_word(0, 16'h0010, 16'hBEEF, 2'b11, "wr_beef");
        rd_word(0, 16'h0010, 16'hBEEF, "rd_beef");

        // Byte lanes; odd address aliases to the same word.
        wr_word(0, 16'h0020, 16'h1234, 2'b11, "wr_1234");
        wr_word(0, 16'h0020, 16'hABCD, 2'b01, "wr_lane0");
        wr_word(0, 16'h0021, 16'hEF00, 2'b10, "wr_lane1");
        rd_word(0, 16'h0020, 16'hEFCD, "rd_lanes");
        rd_word(0, 16'h0021, 16'hEFCD, "rd_lanes_odd");

        // Abort in BUSY: no response, array untouched.
        wr_word(0, 16'h0030, 16'hAAAA, 2'b11, "wr_aaaa");
        rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 16'h0030; wd[0] = 16'h5555; wm[0] = 2'b11;
        @(negedge clk);
        wr[0] = 1'b0;
        resp_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp[0] === 1'b1) resp_seen++;
        end
        chk("abort_no_resp", 32'(resp_seen), 32'h0);
        rd_word(0, 16'h0030, 16'hAAAA, "rd_after_abort");

        // Read+write together: old word returned, new word stored.
        wr_word(0, 16'h0040, 16'h0001, 2'b11, "wr_0001");
        issue(0, 1'b1, 1'b1, 16'h0040, 16'h0002, 2'b11, 1'b1, 16'h0001, "rw_both");
        rd_word(0, 16'h0040, 16'h0002, "rd_after_rw");

        // Mask 00 responds but writes nothing.
        wr_word(0, 16'h0040, 16'hFFFF, 2'b00, "wr_mask00");
        rd_word(0, 16'h0040, 16'h0002, "rd_after_mask00");

        // Reset mid-BUSY discards the write and clears outputs.
        wr_word(0, 16'h0050, 16'h1111, 2'b11, "wr_1111");
        rd_word(0, 16'h0010, 16'hBEEF, "rd_beef_again");
        rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 16'h0050; wd[0] = 16'h9999; wm[0] = 2'b11;
        @(negedge clk);
        rst_n = 1'b0;
        wr[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_resp",  {31'h0, resp[0]}, 32'h0);
        chk("midreset_rdata", {16'h0, rdat[0]}, 32'h0);
        rd_word(0, 16'h0050, 16'h1111, "rd_after_reset");

        // LATENCY=1 and address wrap.
        wr_word(1, 16'h0202, 16'h7777, 2'b11, "l1_wr_7777");
        rd_word(1, 16'h0002, 16'h7777, "l1_rd_wrap");
        wr_word(1, 16'h0405, 16'h5A5A, 2'b11, "l1_wr_5a5a");
        wr_word(1, 16'h0004, 16'h00C3, 2'b01, "l1_wr_lane0");
        rd_word(1, 16'h0004, 16'h5AC3, "l1_rd_lanes");

        repeat (4) @(negedge clk);
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover_expect: got %0d pending required 0", sb0.size() + sb1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
